// File: rtl/pkt_chk_pkg.sv
// Shared definitions for the packet header/sequence checker.
//   state_t     : FSM state encodings (exposed on the debug 'state' port)
//   default_hdr : all-ones constant of a given width, used as the default
//                 required header word.
package pkt_chk_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    FIRST_PKT = 3'd1,
    REG_PKT   = 3'd2,
    F_ERR     = 3'd3,
    SEQ_ERR   = 3'd4
  } state_t;

  function automatic logic [63:0] default_hdr(input int unsigned w);
    logic [63:0] r;
    r = '0;
    for (int unsigned i = 0; i < 64; i++) begin
      if (i < w) r[i] = 1'b1;
    end
    return r;
  endfunction

endpackage

// File: rtl/pkt_chk_seq_cnt.sv
// Expected-sequence register for the packet checker.
//   clk, reset : clock, synchronous active-high reset (clears to 0)
//   load       : expected <= load_val + 1 (resync on an arbitrary seq)
//   inc        : expected <= expected + 1 (in-order packet accepted)
//   load_val   : sequence word of the packet being accepted
//   exp_seq    : current expected sequence number
// Arithmetic wraps modulo 2^WORD_SIZE.
module pkt_chk_seq_cnt #(
  parameter int unsigned WORD_SIZE = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 load,
  input  logic                 inc,
  input  logic [WORD_SIZE-1:0] load_val,
  output logic [WORD_SIZE-1:0] exp_seq
);

  always_ff @(posedge clk) begin
    if (reset) begin
      exp_seq <= '0;
    end else if (load) begin
      exp_seq <= load_val + WORD_SIZE'(1);
    end else if (inc) begin
      exp_seq <= exp_seq + WORD_SIZE'(1);
    end
  end

endmodule

// File: rtl/pkt_seq_checker.sv
// Packet header/sequence checker.
// The input bus is split into BUS_SIZE/WORD_SIZE words: the top word is the
// header (must equal HDR_VAL), the bottom word is a wrapping sequence number.
// Ports:
//   clk, reset     : clock, synchronous active-high reset
//   data_input     : packet bus
//   valid_in       : data_input carries a packet this cycle
//   data_out       : registered copy of the last accepted packet
//   output_control : per-word enables, all ones after a good packet
//   valid_out      : outputs were updated by a packet on the previous edge
//   err            : registered error flag for the previous packet
//   nxt_err        : combinational error decision for the current packet
//   err_count      : saturating count of bad packets
//   state          : current FSM state (debug)
// Build option: define PKT_CHK_AUTORESYNC_EN to let any packet with a good
// header leave an error state regardless of its sequence number; otherwise
// resync requires a good header and sequence 0.
module pkt_seq_checker
  import pkt_chk_pkg::*;
#(
  parameter int unsigned           BUS_SIZE  = 16,
  parameter int unsigned           WORD_SIZE = 4,
  localparam int unsigned          WORD_NUM  = BUS_SIZE / WORD_SIZE,
  parameter logic [WORD_SIZE-1:0]  HDR_VAL   = WORD_SIZE'(default_hdr(WORD_SIZE)),
  parameter int unsigned           ERR_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [BUS_SIZE-1:0]  data_input,
  input  logic                 valid_in,
  output logic [BUS_SIZE-1:0]  data_out,
  output logic [WORD_NUM-1:0]  output_control,
  output logic                 valid_out,
  output logic                 err,
  output logic                 nxt_err,
  output logic [ERR_CNT_W-1:0] err_count,
  output logic [2:0]           state
);

  state_t               state_q, state_d;
  logic [WORD_SIZE-1:0] hdr, seq, exp_seq;
  logic                 hdr_ok, seq_ok, resync;
  logic                 accept, seq_load, seq_inc;

  assign hdr    = data_input[BUS_SIZE-1 -: WORD_SIZE];
  assign seq    = data_input[WORD_SIZE-1:0];
  assign hdr_ok = (hdr == HDR_VAL);
  assign seq_ok = (seq == exp_seq);

`ifdef PKT_CHK_AUTORESYNC_EN
  assign resync = hdr_ok;
`else
  assign resync = hdr_ok && (seq == '0);
`endif

  pkt_chk_seq_cnt #(
    .WORD_SIZE (WORD_SIZE)
  ) u_seq_cnt (
    .clk      (clk),
    .reset    (reset),
    .load     (seq_load),
    .inc      (seq_inc),
    .load_val (seq),
    .exp_seq  (exp_seq)
  );

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    accept   = 1'b0;
    seq_load = 1'b0;
    seq_inc  = 1'b0;
    if (valid_in) begin
      case (state_q)
        IDLE, FIRST_PKT, REG_PKT: begin
          if (!hdr_ok) begin
            state_d = F_ERR;
          end else if (!seq_ok) begin
            state_d = SEQ_ERR;
          end else begin
            state_d = (state_q == IDLE) ? FIRST_PKT : REG_PKT;
            accept  = 1'b1;
            seq_inc = 1'b1;
          end
        end
        F_ERR, SEQ_ERR: begin
          if (resync) begin
            state_d  = FIRST_PKT;
            accept   = 1'b1;
            seq_load = 1'b1;
          end else if (!hdr_ok) begin
            state_d = F_ERR;
          end else begin
            state_d = SEQ_ERR;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // With valid_in low the state holds, possibly in an error state, so the
  // error decision must be qualified by valid_in.
  assign nxt_err = valid_in && ((state_d == F_ERR) || (state_d == SEQ_ERR));
  assign state   = state_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      data_out       <= '0;
      output_control <= '0;
      valid_out      <= 1'b0;
      err            <= 1'b0;
      err_count      <= '0;
    end else begin
      valid_out <= valid_in;
      if (valid_in) begin
        err <= nxt_err;
        if (accept) begin
          data_out       <= data_input;
          output_control <= '1;
        end else begin
          output_control <= '0;
        end
        if (nxt_err && (err_count != '1)) begin
          err_count <= err_count + ERR_CNT_W'(1);
        end
      end
    end
  end

endmodule
